// File: rtl/vector_exec_unit.sv
// Vector execute stage: latches two operand vectors, runs one element-wise op over
// LANES elements per cycle, then presents the result on the register-file write port.
module vector_exec_unit #(
   parameter int WIDTH        = 16,
   parameter int VECTOR_SIZE  = 16,
   parameter int NUM_VECTORES = 8,
   parameter int LANES        = 4
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    start,
   input  logic [2:0]                              op,
   input  logic [$clog2(NUM_VECTORES)-1:0]         vdst,
   input  logic [VECTOR_SIZE-1:0][WIDTH-1:0]       vs1,
   input  logic [VECTOR_SIZE-1:0][WIDTH-1:0]       vs2,
   output logic                                    busy,
   output logic                                    done,
   output logic                                    we3,
   output logic [$clog2(NUM_VECTORES)-1:0]         v3,
   output logic [VECTOR_SIZE-1:0][WIDTH-1:0]       wd3
);

   localparam int N     = VECTOR_SIZE / LANES;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int EL_W  = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
   localparam int SH_W  = $clog2(WIDTH);
   localparam int VI_W  = $clog2(NUM_VECTORES);

   generate
      if ((VECTOR_SIZE % LANES) != 0) begin : g_bad_lanes
         $error("VECTOR_SIZE must be an integer multiple of LANES");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   // Element-wise operation; results wrap to WIDTH bits, shifts use only low SH_W bits of b.
   function automatic logic [WIDTH-1:0] f_alu(input logic [2:0]       i_op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      logic [2*WIDTH-1:0] prod;
      logic [SH_W-1:0]    sh;
      prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      sh   = b[SH_W-1:0];
      case (i_op)
         3'b000:  f_alu = a + b;
         3'b001:  f_alu = a - b;
         3'b010:  f_alu = a & b;
         3'b011:  f_alu = a | b;
         3'b100:  f_alu = a ^ b;
         3'b101:  f_alu = a << sh;
         3'b110:  f_alu = a >> sh;
         3'b111:  f_alu = prod[WIDTH-1:0];
         default: f_alu = {WIDTH{1'b0}};
      endcase
   endfunction

   state_t                              r_state;
   state_t                              w_state_nxt;
   logic [2:0]                          r_op;
   logic [VI_W-1:0]                     r_vdst;
   logic [VECTOR_SIZE-1:0][WIDTH-1:0]   r_a;
   logic [VECTOR_SIZE-1:0][WIDTH-1:0]   r_b;
   logic [VECTOR_SIZE-1:0][WIDTH-1:0]   r_res;
   logic [CNT_W-1:0]                    r_cnt;
   logic [VI_W-1:0]                     r_v3;
   logic [VECTOR_SIZE-1:0][WIDTH-1:0]   r_wd3;
   logic [EL_W-1:0]                     w_el_idx [LANES];
   logic [WIDTH-1:0]                    w_lane_res [LANES];
   logic [VECTOR_SIZE-1:0][WIDTH-1:0]   w_res_nxt;
   logic                                w_last;

   assign w_last = (r_cnt == CNT_W'(N - 1));

   // Only LANES ALUs exist; the lane counter steers them across the element groups.
   generate
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         assign w_el_idx[l]   = EL_W'(r_cnt) * EL_W'(LANES) + EL_W'(l);
         assign w_lane_res[l] = f_alu(r_op, r_a[w_el_idx[l]], r_b[w_el_idx[l]]);
      end
   endgenerate

   // Result buffer with the current lane group merged in.
   always_comb begin
      w_res_nxt = r_res;
      for (int l = 0; l < LANES; l++) begin
         w_res_nxt[w_el_idx[l]] = w_lane_res[l];
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_EXEC;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_EXEC: begin
            if (w_last) begin
               w_state_nxt = S_WB;
            end else begin
               w_state_nxt = S_EXEC;
            end
         end
         S_WB:    w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand capture, lane stepping and write-port data holding.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op   <= 3'b000;
         r_vdst <= {VI_W{1'b0}};
         r_a    <= '0;
         r_b    <= '0;
         r_res  <= '0;
         r_cnt  <= {CNT_W{1'b0}};
         r_v3   <= {VI_W{1'b0}};
         r_wd3  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op   <= op;
                  r_vdst <= vdst;
                  r_a    <= vs1;
                  r_b    <= vs2;
                  r_cnt  <= {CNT_W{1'b0}};
               end else begin
                  r_cnt  <= r_cnt;
               end
            end
            S_EXEC: begin
               r_res <= w_res_nxt;
               if (w_last) begin
                  r_cnt <= {CNT_W{1'b0}};
                  r_wd3 <= w_res_nxt;
                  r_v3  <= r_vdst;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   assign busy = (r_state == S_EXEC) || (r_state == S_WB);
   assign done = (r_state == S_WB);
   assign we3  = (r_state == S_WB);
   assign v3   = r_v3;
   assign wd3  = r_wd3;

endmodule

// File: doc/vector_exec_unit.md
Name: vector_exec_unit

Overview:
- Vector execute stage directly downstream of the vector register file.
- Consumes the two read vectors (vd1, vd2), applies one element-wise operation over LANES elements per cycle, buffers the result vector, then drives the register-file write port (we3, v3, wd3) for exactly one cycle.
- Multi-cycle unit with a start/busy/done handshake toward the decode/control logic.

Parameters:
- WIDTH, 16, element width in bits.
- VECTOR_SIZE, 16, elements per vector.
- NUM_VECTORES, 8, number of vector registers; sets index width $clog2(NUM_VECTORES).
- LANES, 4, elements processed per cycle. VECTOR_SIZE must be an integer multiple of LANES; elaboration error otherwise.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation code, latched with start.
- vdst  in  $clog2(NUM_VECTORES)  destination register index, latched with start.
- vs1  in  WIDTH x VECTOR_SIZE  operand A; connects to register-file vd1.
- vs2  in  WIDTH x VECTOR_SIZE  operand B; connects to register-file vd2.
- busy  out  1  high in EXEC and WB.
- done  out  1  one-cycle pulse in WB.
- we3  out  1  register-file write enable.
- v3  out  $clog2(NUM_VECTORES)  register-file write index.
- wd3  out  WIDTH x VECTOR_SIZE  register-file write data.

Behaviour:
- Reset, when rst_n=0 at a rising edge: state=IDLE; busy, done, we3 = 0; v3 = 0; all wd3 elements = 0; lane counter = 0. Reset overrides everything.
- Reset mid-EXEC or mid-WB aborts the operation. No write is issued afterward, and a we3 that was high drops at that edge.
- States: IDLE, EXEC, WB.
- IDLE:
  - At an edge with start=1, latch op, vdst, vs1 and vs2 into operand buffers, clear the lane counter, and go to EXEC.
  - With start=0, stay in IDLE.
- EXEC:
  - Each edge computes elements [cnt*LANES, cnt*LANES+LANES-1] from the latched operands into the result buffer, then increments cnt.
  - After N = VECTOR_SIZE/LANES edges, go to WB.
  - The vs1/vs2 inputs are don't-care after the start edge.
- WB:
  - Combinationally from state: we3=1, done=1, v3=latched vdst, wd3=result buffer.
  - Next edge goes to IDLE.
- Latency: with start sampled at edge E0, we3/done are high for the cycle between edges E0+N and E0+N+1. The register file captures the data at E0+N+1. Default N=4, so 5 edges from start to the write.
- Back-to-back: start is ignored while busy=1, and the ignored request is not queued. start=1 during the WB cycle is also ignored. A new start is accepted at the first edge in IDLE, one cycle after WB.
- Outside WB: we3=0 and done=0. wd3 and v3 hold their last values (zero after reset).
- Operations per element, with a and b being WIDTH bits and results truncated to WIDTH (wrap, no saturation, no flags):
  - 000 ADD a+b
  - 001 SUB a-b
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL a<<b[3:0]
  - 110 SHR logical a>>b[3:0]
  - 111 MUL, low WIDTH bits of a*b
- Shift amount uses only the low $clog2(WIDTH) bits of b.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with start=1 → busy, done and we3 stay 0, all wd3 elements = 0, v3=0, no write issued.
- ADD latency: vs1 all 0xABCD, vs2 all 0x1111, op=000, vdst=2, start for one cycle → we3=1 exactly 5 edges after the start edge, for one cycle. v3=2, all 16 wd3 elements = 0xBCDE, done pulses once, busy high for 5 cycles.
- Wrap arithmetic: SUB with vs1=0x1111, vs2=0xABCD → every element 0x6544. MUL with 0x0100*0x0100 → 0x0000. MUL with 0x00FF*0x0101 → 0xFFFF.
- Per-lane distinctness and shifts:
  - vs1[i]=i, vs2[i]=i, op=101 → wd3[i] = (i<<i) mod 2^16, e.g. element 15 = 0x8000 and element 4 = 0x0040. Checks that lane groups are not mixed.
  - vs2=0x001F, vs1=0x0001 → 0x8000 (shift amount 15).
- Handshake: XOR (0xABCD^0x1111=0xBADC) to vdst=4; pulse start again in EXEC and in WB → both ignored, single we3 pulse. Change vs1 during EXEC → result unaffected. New start in the first IDLE cycle → accepted.
- Reset mid-operation: drop rst_n for 1 cycle at the 2nd EXEC edge → state IDLE, we3 never asserts for that op, wd3=0. A subsequent ADD completes normally.
